wb_regfile: RTL and testbench

Write-back stage and architectural register file of the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value with MemtoReg, and commits it to a 32-entry register file on the rising clock edge. Serves the ID stage through two read ports with same-cycle write-to-read bypass. Drives a registered commit trace and a commit counter for the verification bench.

---
 rtl/wb_regfile.sv | 93 +++++++++
 tb/tb_wb_regfile.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// It selects the write-back value, commits it to a 2**ADDR_WIDTH entry
// register file, and serves two combinational read ports that bypass a
// same-cycle write. It also drives a registered commit trace and a commit
// counter.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWrite_i,
    input  logic [1:0]             MemtoReg_i,
    input  logic [ADDR_WIDTH-1:0]  Addr_i,
    input  logic [DATA_WIDTH-1:0]  Mem_Data_i,
    input  logic [DATA_WIDTH-1:0]  ALU_Data_i,
    input  logic [DATA_WIDTH-1:0]  PC_Plus4_i,
    input  logic [ADDR_WIDTH-1:0]  Read_Reg1_i,
    input  logic [ADDR_WIDTH-1:0]  Read_Reg2_i,
    output logic [DATA_WIDTH-1:0]  Read_Data1_o,
    output logic [DATA_WIDTH-1:0]  Read_Data2_o,
    output logic [DATA_WIDTH-1:0]  WB_Data_o,
    output logic                   Commit_Valid_o,
    output logic [ADDR_WIDTH-1:0]  Commit_Addr_o,
    output logic [DATA_WIDTH-1:0]  Commit_Data_o,
    output logic [COUNT_WIDTH-1:0] Commit_Count_o
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  we_eff;

    // A write takes effect only outside reset and never to register 0.
    assign we_eff = RegWrite_i && (Addr_i != '0) && !reset;

    // Write-back source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        WB_Data_o = ALU_Data_i;
        case (MemtoReg_i)
            2'b01:   WB_Data_o = Mem_Data_i;
            2'b10:   WB_Data_o = PC_Plus4_i;
            default: WB_Data_o = ALU_Data_i;
        endcase
    end

    // Register storage: cleared on reset, one write per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we_eff) begin
            regs[Addr_i] <= WB_Data_o;
        end
    end

    // Read ports: register 0 is hard zero, and a same-cycle write is bypassed.
    always_comb begin
        Read_Data1_o = regs[Read_Reg1_i];
        if (Read_Reg1_i == '0) begin
            Read_Data1_o = '0;
        end else if (we_eff && (Read_Reg1_i == Addr_i)) begin
            Read_Data1_o = WB_Data_o;
        end

        Read_Data2_o = regs[Read_Reg2_i];
        if (Read_Reg2_i == '0) begin
            Read_Data2_o = '0;
        end else if (we_eff && (Read_Reg2_i == Addr_i)) begin
            Read_Data2_o = WB_Data_o;
        end
    end

    // Commit trace and counter. The counter wraps freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            Commit_Valid_o <= 1'b0;
            Commit_Addr_o  <= '0;
            Commit_Data_o  <= '0;
            Commit_Count_o <= '0;
        end else begin
            Commit_Valid_o <= we_eff;
            Commit_Addr_o  <= Addr_i;
            Commit_Data_o  <= WB_Data_o;
            if (we_eff) begin
                Commit_Count_o <= Commit_Count_o + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile.
// It applies directed table vectors and randomized traffic. A behavioural
// register-file model checks the results. A second instance, built with a
// 4-bit counter, checks counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  addr;
    logic [31:0] mem_d, alu_d, pc_d;
    logic [4:0]  r1, r2;

    logic [31:0] rd1, rd2, wb, cd, cnt;
    logic        cv;
    logic [4:0]  ca;

    logic [31:0] s_rd1, s_rd2, s_wb, s_cd;
    logic        s_cv;
    logic [4:0]  s_ca;
    logic [3:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit [31:0]   mreg [32];
    bit          mvalid;
    bit [4:0]    maddr;
    bit [31:0]   mdata;
    int unsigned mcount;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .RegWrite_i(rw), .MemtoReg_i(mtr), .Addr_i(addr),
        .Mem_Data_i(mem_d), .ALU_Data_i(alu_d), .PC_Plus4_i(pc_d),
        .Read_Reg1_i(r1), .Read_Reg2_i(r2), .Read_Data1_o(rd1), .Read_Data2_o(rd2),
        .WB_Data_o(wb), .Commit_Valid_o(cv), .Commit_Addr_o(ca), .Commit_Data_o(cd),
        .Commit_Count_o(cnt)
    );

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .RegWrite_i(rw), .MemtoReg_i(mtr), .Addr_i(addr),
        .Mem_Data_i(mem_d), .ALU_Data_i(alu_d), .PC_Plus4_i(pc_d),
        .Read_Reg1_i(r1), .Read_Reg2_i(r2), .Read_Data1_o(s_rd1), .Read_Data2_o(s_rd2),
        .WB_Data_o(s_wb), .Commit_Valid_o(s_cv), .Commit_Addr_o(s_ca), .Commit_Data_o(s_cd),
        .Commit_Count_o(s_cnt)
    );

    typedef struct {
        bit        rst;
        bit        rw;
        bit [1:0]  mtr;
        bit [4:0]  addr;
        bit [31:0] alu;
        bit [31:0] mem;
        bit [31:0] pc;
        bit [4:0]  r1;
        bit [4:0]  r2;
        bit [31:0] exp_rd1;  // before the edge
        bit [31:0] exp_rd2;
        bit [31:0] exp_wb;
        bit        exp_cv;   // after the edge
        bit [31:0] exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] m_wb(input vec_t v);
        if (v.mtr == 2'd1) return v.mem;
        if (v.mtr == 2'd2) return v.pc;
        return v.alu;
    endfunction

    function automatic bit m_we(input vec_t v);
        return v.rw && (v.addr != 0) && !v.rst;
    endfunction

    function automatic bit [31:0] m_read(input vec_t v, input bit [4:0] idx);
        if (idx == 0) return 32'd0;
        if (m_we(v) && idx == v.addr) return m_wb(v);
        return mreg[idx];
    endfunction

    // One clock cycle. The task is entered just after a rising edge.
    task automatic cycle(input vec_t v, input bit use_exp);
        bit [31:0] w;
        reset = v.rst; rw = v.rw; mtr = v.mtr; addr = v.addr;
        alu_d = v.alu; mem_d = v.mem; pc_d = v.pc; r1 = v.r1; r2 = v.r2;
        @(negedge clk);
        w = m_wb(v);
        chk("wb_data", wb, w);
        chk("read1", rd1, m_read(v, v.r1));
        chk("read2", rd2, m_read(v, v.r2));
        chk("w4_read1", s_rd1, m_read(v, v.r1));
        if (use_exp) begin
            chk("vec_read1", rd1, v.exp_rd1);
            chk("vec_read2", rd2, v.exp_rd2);
            chk("vec_wb", wb, v.exp_wb);
        end
        @(posedge clk);
        if (v.rst) begin
            foreach (mreg[i]) mreg[i] = 0;
            mvalid = 0; maddr = 0; mdata = 0; mcount = 0;
        end else begin
            mvalid = m_we(v);
            maddr  = v.addr;
            mdata  = w;
            if (m_we(v)) begin
                mreg[v.addr] = w;
                mcount++;
            end
        end
        #1;
        chk("commit_valid", {31'd0, cv}, {31'd0, mvalid});
        chk("commit_count", cnt, mcount);
        chk("w4_count", {28'd0, s_cnt}, {28'd0, mcount[3:0]});
        chk("w4_valid", {31'd0, s_cv}, {31'd0, mvalid});
        if (mvalid) begin
            chk("commit_addr", {27'd0, ca}, {27'd0, maddr});
            chk("commit_data", cd, mdata);
            chk("w4_commit", {s_ca, s_cd[26:0]}, {maddr, mdata[26:0]});
            chk("w4_rd2_wb", s_rd2 ^ s_wb, rd2 ^ wb);
        end
        if (use_exp) begin
            chk("vec_commit_valid", {31'd0, cv}, {31'd0, v.exp_cv});
            chk("vec_count", cnt, v.exp_cnt);
        end
    endtask

    vec_t vecs [15];
    vec_t v;

    initial begin
        //           rst rw mtr addr alu           mem    pc            r1  r2  rd1           rd2   wb            cv cnt
        vecs[0]  = '{0, 1, 0, 5,  32'h12345678, 0,     0,            5,  0,  32'h12345678, 0,    32'h12345678, 1, 1};
        vecs[1]  = '{1, 1, 0, 6,  32'hFFFFFFFF, 0,     0,            5,  6,  32'h12345678, 0,    32'hFFFFFFFF, 0, 0};
        vecs[2]  = '{0, 0, 0, 0,  0,            0,     0,            5,  6,  0,            0,    0,            0, 0};
        vecs[3]  = '{0, 1, 0, 3,  32'hA,        32'hB, 32'hC,        3,  0,  32'hA,        0,    32'hA,        1, 1};
        vecs[4]  = '{0, 1, 1, 3,  32'hA,        32'hB, 32'hC,        3,  0,  32'hB,        0,    32'hB,        1, 2};
        vecs[5]  = '{0, 1, 2, 3,  32'hA,        32'hB, 32'hC,        3,  0,  32'hC,        0,    32'hC,        1, 3};
        vecs[6]  = '{0, 1, 3, 3,  32'hA,        32'hB, 32'hC,        3,  0,  32'hA,        0,    32'hA,        1, 4};
        vecs[7]  = '{0, 0, 0, 3,  32'h55,       0,     0,            3,  3,  32'hA,        32'hA, 32'h55,      0, 4};
        vecs[8]  = '{0, 1, 0, 0,  32'hDEADBEEF, 0,     0,            0,  0,  0,            0,    32'hDEADBEEF, 0, 4};
        vecs[9]  = '{0, 1, 0, 7,  32'h1,        0,     0,            7,  7,  32'h1,        32'h1, 32'h1,       1, 5};
        vecs[10] = '{0, 1, 0, 7,  32'h99,       0,     0,            7,  7,  32'h99,       32'h99, 32'h99,     1, 6};
        vecs[11] = '{0, 0, 0, 7,  32'h77,       0,     0,            7,  7,  32'h99,       32'h99, 32'h77,     0, 6};
        vecs[12] = '{0, 1, 0, 7,  32'h1,        0,     0,            7,  7,  32'h1,        32'h1, 32'h1,       1, 7};
        vecs[13] = '{0, 0, 0, 7,  32'h99,       0,     0,            7,  7,  32'h1,        32'h1, 32'h99,      0, 7};
        vecs[14] = '{0, 1, 2, 31, 0,            0,     32'h00400010, 31, 7,  32'h00400010, 32'h1, 32'h00400010, 1, 8};

        reset = 1'b1; rw = 0; mtr = 0; addr = 0; alu_d = 0; mem_d = 0; pc_d = 0; r1 = 0; r2 = 0;
        @(posedge clk); #1;

        // Initial reset
        v = '{default: 0};
        v.rst = 1;
        cycle(v, 0);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i], 1);
        end
        chk("trace_addr31", {27'd0, ca}, 32'd31);
        chk("trace_data", cd, 32'h00400010);

        // Counter wrap on the 4-bit instance: 17 writes after a reset give 1
        v = '{default: 0};
        v.rst = 1;
        cycle(v, 0);
        for (int i = 0; i < 17; i++) begin
            v = '{default: 0};
            v.rw   = 1;
            v.addr = 5'($urandom_range(1, 31));
            v.alu  = $urandom;
            v.r1   = v.addr;
            cycle(v, 0);
        end
        chk("wrap_count4", {28'd0, s_cnt}, 32'd1);
        chk("wrap_count32", cnt, 32'd17);

        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 600; i++) begin
            v.rst  = ($urandom_range(0, 59) == 0);
            v.rw   = ($urandom_range(0, 3) != 0);
            v.mtr  = 2'($urandom_range(0, 3));
            v.addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            v.alu  = $urandom;
            v.mem  = $urandom;
            v.pc   = $urandom;
            v.r1   = ($urandom_range(0, 2) == 0) ? v.addr : 5'($urandom_range(0, 7));
            v.r2   = ($urandom_range(0, 2) == 0) ? v.addr : 5'($urandom);
            cycle(v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
